// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch digit source: FSM states,
// digit layout, segment bit positions and the BCD to 7-segment mapping.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_LAP   = 2'd3
   } sw_state_t;

   localparam int NUM_DIGITS = 9;

   localparam int SEG_TOP = 0;
   localparam int SEG_UL  = 1;
   localparam int SEG_UR  = 2;
   localparam int SEG_MID = 3;
   localparam int SEG_LR  = 4;
   localparam int SEG_LL  = 5;
   localparam int SEG_BOT = 6;

   localparam logic [6:0] SEG_ZERO  = 7'b1110111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   // Per-digit maximum, digit k in [4k+3:4k]: HH 99, MM 59, SS 59, mmm 999.
   localparam logic [35:0] DIGIT_MAX = 36'h999959599;

   function automatic logic [6:0] seg_mask(input int idx);
      seg_mask = 7'b0000001 << idx;
   endfunction

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] m;
      m = SEG_BLANK;
      case (d)
         4'd0: m = seg_mask(SEG_TOP) | seg_mask(SEG_UL) | seg_mask(SEG_UR) |
                   seg_mask(SEG_LR) | seg_mask(SEG_LL) | seg_mask(SEG_BOT);
         4'd1: m = seg_mask(SEG_UR) | seg_mask(SEG_LR);
         4'd2: m = seg_mask(SEG_TOP) | seg_mask(SEG_UR) | seg_mask(SEG_MID) |
                   seg_mask(SEG_LL) | seg_mask(SEG_BOT);
         4'd3: m = seg_mask(SEG_TOP) | seg_mask(SEG_UR) | seg_mask(SEG_MID) |
                   seg_mask(SEG_LR) | seg_mask(SEG_BOT);
         4'd4: m = seg_mask(SEG_UL) | seg_mask(SEG_UR) | seg_mask(SEG_MID) |
                   seg_mask(SEG_LR);
         4'd5: m = seg_mask(SEG_TOP) | seg_mask(SEG_UL) | seg_mask(SEG_MID) |
                   seg_mask(SEG_LR) | seg_mask(SEG_BOT);
         4'd6: m = seg_mask(SEG_TOP) | seg_mask(SEG_UL) | seg_mask(SEG_MID) |
                   seg_mask(SEG_LR) | seg_mask(SEG_LL) | seg_mask(SEG_BOT);
         4'd7: m = seg_mask(SEG_TOP) | seg_mask(SEG_UR) | seg_mask(SEG_LR);
         4'd8: m = 7'b1111111;
         4'd9: m = seg_mask(SEG_TOP) | seg_mask(SEG_UL) | seg_mask(SEG_UR) |
                   seg_mask(SEG_MID) | seg_mask(SEG_LR) | seg_mask(SEG_BOT);
         default: m = SEG_BLANK;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/sw_seg7_encode.sv
// Combinational BCD digit to 7-segment mask (1 = lit); codes above 9 are dark.
module sw_seg7_encode
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/stopwatch_digit_source.sv
// Stopwatch timekeeper: ms prescaler, cascaded BCD counters, start/stop/lap/clear
// FSM, and a frame-synchronous output register feeding the display.
module stopwatch_digit_source
   import stopwatch_pkg::*;
#(
   parameter int MS_DIV = 100000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start_stop,
   input  logic        lap,
   input  logic        clear,
   input  logic        frame_sync,
   output logic [35:0] digit_bcd,
   output logic [62:0] seg,
   output logic        running,
   output logic        lap_active,
   output logic        wrap
);

   localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

   sw_state_t   state_q, state_d;
   logic [PW-1:0] presc_q;
   logic [35:0] live_q, live_d;
   logic [35:0] lap_q;
   logic [35:0] src_bcd;
   logic [62:0] src_seg;
   logic        counting, ms_tick, carry, lap_capture;
   logic        run_d, lap_d;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state; clear beats start_stop, which beats lap.
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_IDLE;
      end else if (start_stop) begin
         case (state_q)
            ST_IDLE:  state_d = ST_RUN;
            ST_RUN:   state_d = ST_PAUSE;
            ST_LAP:   state_d = ST_PAUSE;
            ST_PAUSE: state_d = ST_RUN;
            default:  state_d = ST_IDLE;
         endcase
      end else if (lap) begin
         case (state_q)
            ST_RUN:  state_d = ST_LAP;
            ST_LAP:  state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM-derived controls.
   always_comb begin
      counting    = (state_q == ST_RUN) || (state_q == ST_LAP);
      lap_capture = !clear && !start_stop && lap && (state_q == ST_RUN);
      run_d       = (state_d == ST_RUN) || (state_d == ST_LAP);
      lap_d       = (state_d == ST_LAP);
   end

   assign ms_tick = counting && (presc_q == PW'(MS_DIV - 1));

   // Ripple the tick from ms-units (digit 8) up to hour-tens (digit 0);
   // carry surviving past digit 0 means the whole display rolled over.
   always_comb begin
      live_d = live_q;
      carry  = ms_tick;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         if (carry) begin
            if (live_q[4*k +: 4] == DIGIT_MAX[4*k +: 4]) begin
               live_d[4*k +: 4] = 4'd0;
            end else begin
               live_d[4*k +: 4] = live_q[4*k +: 4] + 4'd1;
               carry            = 1'b0;
            end
         end
      end
   end

   assign src_bcd = (state_q == ST_LAP) ? lap_q : live_q;

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
      sw_seg7_encode u_enc (
         .bcd (src_bcd[4*k +: 4]),
         .seg (src_seg[7*k +: 7])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         presc_q    <= '0;
         live_q     <= '0;
         lap_q      <= '0;
         digit_bcd  <= '0;
         seg        <= {NUM_DIGITS{SEG_ZERO}};
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         if (clear) begin
            presc_q <= '0;
            live_q  <= '0;
         end else begin
            if (counting) presc_q <= ms_tick ? '0 : presc_q + PW'(1);
            live_q <= live_d;
         end
         if (lap_capture) lap_q <= live_q;
         // The output register is the shadow: it only moves on frame_sync.
         if (frame_sync) begin
            digit_bcd <= src_bcd;
            seg       <= src_seg;
         end
         running    <= run_d;
         lap_active <= lap_d;
         wrap       <= carry && !clear;
      end
   end

endmodule

// File: tb/tb_stopwatch_digit_source.sv
// Self-checking bench for stopwatch_digit_source with MS_DIV = 4.
module tb_stopwatch_digit_source;

   localparam int MS_DIV = 4;
   localparam int W      = 101;
   localparam int NROWS  = 14;

   logic        clk = 1'b0;
   logic        rst, start_stop, lap, clear, frame_sync;
   logic [35:0] digit_bcd;
   logic [62:0] seg;
   logic        running, lap_active, wrap;

   typedef struct {
      bit ss;
      bit lp;
      bit cl;
      int n;
      int exp_ms;
      bit exp_run;
      bit exp_lap;
   } row_t;

   row_t        rows [NROWS];
   logic [W-1:0] exp_q [$];
   logic [6:0]  seg_lut [16];
   logic [35:0] dep_v;
   int          tests    = 0;
   int          failed   = 0;
   int          wrap_cnt = 0;

   stopwatch_digit_source #(.MS_DIV(MS_DIV)) dut (
      .CLK        (clk),
      .RST        (rst),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .frame_sync (frame_sync),
      .digit_bcd  (digit_bcd),
      .seg        (seg),
      .running    (running),
      .lap_active (lap_active),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [35:0] ms_to_bcd(input int ms);
      int hh, mm, ss, mmm;
      logic [35:0] r;
      hh  = ms / 3600000;
      mm  = (ms / 60000) % 60;
      ss  = (ms / 1000) % 60;
      mmm = ms % 1000;
      r[3:0]   = 4'(hh / 10);
      r[7:4]   = 4'(hh % 10);
      r[11:8]  = 4'(mm / 10);
      r[15:12] = 4'(mm % 10);
      r[19:16] = 4'(ss / 10);
      r[23:20] = 4'(ss % 10);
      r[27:24] = 4'(mmm / 100);
      r[31:28] = 4'((mmm / 10) % 10);
      r[35:32] = 4'(mmm % 10);
      return r;
   endfunction

   function automatic logic [62:0] seg_of(input logic [35:0] bcd);
      logic [62:0] r;
      for (int k = 0; k < 9; k++) r[7*k +: 7] = seg_lut[bcd[4*k +: 4]];
      return r;
   endfunction

   function automatic logic [W-1:0] mk(input logic [35:0] bcd, input bit r, input bit l);
      return {bcd, seg_of(bcd), r, l};
   endfunction

   task automatic cyc(input bit ss, input bit lp, input bit cl, input bit fs);
      start_stop = ss;
      lap        = lp;
      clear      = cl;
      frame_sync = fs;
      @(negedge clk);
      if (wrap) wrap_cnt++;
      start_stop = 1'b0;
      lap        = 1'b0;
      clear      = 1'b0;
      frame_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [W-1:0] exp);
      logic [W-1:0] act;
      act = {digit_bcd, seg, running, lap_active};
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got bcd=%h seg=%h run=%b lap=%b, expected bcd=%h seg=%h run=%b lap=%b",
                  name, act[100:65], act[64:2], act[1], act[0],
                  exp[100:65], exp[64:2], exp[1], exp[0]);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic pop_check(input string name);
      if (exp_q.size() == 0) begin
         tests++;
         failed++;
         $display("FAIL %s: got an output with no expected entry, expected a queued entry", name);
      end else begin
         check(name, exp_q.pop_front());
      end
   endtask

   task automatic frame(input string name, input logic [W-1:0] exp);
      exp_q.push_back(exp);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      pop_check(name);
   endtask

   task automatic deposit(input logic [35:0] v);
      dep_v = v;
      force dut.live_q = dep_v;
      #1;
      release dut.live_q;
   endtask

   task automatic carry_check(input string name, input int dep_ms);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      deposit(ms_to_bcd(dep_ms));
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      frame(name, mk(ms_to_bcd(dep_ms + 1), 1'b1, 1'b0));
   endtask

   initial begin
      seg_lut[0] = 7'b1110111;  seg_lut[1] = 7'b0010100;
      seg_lut[2] = 7'b1101101;  seg_lut[3] = 7'b1011101;
      seg_lut[4] = 7'b0011110;  seg_lut[5] = 7'b1011011;
      seg_lut[6] = 7'b1111011;  seg_lut[7] = 7'b0010101;
      seg_lut[8] = 7'b1111111;  seg_lut[9] = 7'b1011111;
      for (int i = 10; i < 16; i++) seg_lut[i] = 7'b0000000;

      // {ss, lap, clear, idle cycles before frame_sync, shown ms, running, lap_active}
      rows[0]  = '{1, 0, 0, 4000, 1000, 1, 0};
      rows[1]  = '{1, 0, 0, 1000, 1000, 0, 0};
      rows[2]  = '{1, 0, 0,    5, 1001, 1, 0};
      rows[3]  = '{0, 1, 0,   40, 1002, 1, 1};
      rows[4]  = '{0, 1, 0,   10, 1015, 1, 0};
      rows[5]  = '{1, 1, 0,    3, 1015, 0, 0};
      rows[6]  = '{0, 1, 0,    3, 1015, 0, 0};
      rows[7]  = '{1, 0, 0,    1, 1016, 1, 0};
      rows[8]  = '{1, 0, 1,    2,    0, 0, 0};
      rows[9]  = '{0, 1, 0,    2,    0, 0, 0};
      rows[10] = '{1, 0, 0,    8,    2, 1, 0};
      rows[11] = '{0, 1, 0,   20,    2, 1, 1};
      rows[12] = '{1, 0, 0,    4,    8, 0, 0};
      rows[13] = '{0, 1, 1,    1,    0, 0, 0};

      rst = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; frame_sync = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset", mk(36'h0, 1'b0, 1'b0));
      check_int("reset_wrap", int'(wrap), 0);

      for (int i = 0; i < NROWS; i++) begin
         cyc(rows[i].ss, rows[i].lp, rows[i].cl, 1'b0);
         idle(rows[i].n);
         frame($sformatf("row%0d", i), mk(ms_to_bcd(rows[i].exp_ms), rows[i].exp_run, rows[i].exp_lap));
      end

      // clear+start_stop in RUN: display holds until the next frame_sync.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(10);
      frame("clr_pre", mk(ms_to_bcd(2), 1'b1, 1'b0));
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      idle(3);
      check("clr_hold", mk(ms_to_bcd(2), 1'b0, 1'b0));
      frame("clr_zero", mk(36'h0, 1'b0, 1'b0));

      // Out-of-range digit code renders dark.
      deposit(36'h0000B0000);
      frame("blank", mk(36'h0000B0000, 1'b0, 1'b0));

      carry_check("carry_sec", 999);
      carry_check("carry_min", 59999);
      carry_check("carry_10min", 599999);
      carry_check("carry_hour", 35999999);
      check_int("no_wrap", wrap_cnt, 0);

      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      deposit(ms_to_bcd(359999999));
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      idle(20);
      check_int("wrap_pulse", wrap_cnt, 1);
      frame("wrap_cont", mk(ms_to_bcd(4), 1'b1, 1'b0));

      // Reset in LAP with commands pending.
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      frame("lap_pre_rst", mk(ms_to_bcd(4), 1'b1, 1'b1));
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      rst = 1'b0;
      check("rst_mid", mk(36'h0, 1'b0, 1'b0));
      idle(5);
      frame("rst_idle", mk(36'h0, 1'b0, 1'b0));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
